// File: rtl/j_txsched_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM encoding and write-data padding.
package j_txsched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WR    = 3'd1,
        ST_WLOW  = 3'd2,
        ST_WHIGH = 3'd3,
        ST_BRK   = 3'd4
    } state_t;

    localparam logic [7:0] DIN_PAD = 8'h00;

endpackage

// File: rtl/j_txfifo.sv
// DEPTH x 8 synchronous FIFO; head of queue is presented combinationally on rdata.
module j_txfifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     sys_clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               wdata,
    output logic [7:0]               rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == FULL_CNT);
    assign empty   = (cnt == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset; pointers alone define valid contents.
    always_ff @(posedge sys_clk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/j_txsched.sv
// UART transmit scheduler: round-robin arbitration of two byte sources into a FIFO,
// drained into the transmitter holding register with tbe pacing and break timing.
module j_txsched
    import j_txsched_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TMO   = 64,
    parameter int unsigned BRKW  = 16
) (
    input  logic                     sys_clk,
    input  logic                     reset,
    input  logic                     req_a,
    input  logic [7:0]               data_a,
    output logic                     gnt_a,
    input  logic                     req_b,
    input  logic [7:0]               data_b,
    output logic                     gnt_b,
    input  logic                     brk_go,
    input  logic [BRKW-1:0]          brk_len,
    input  logic                     tbe,
    output logic                     u2dwr,
    output logic [15:0]              din,
    output logic                     txbrk,
    output logic [$clog2(DEPTH):0]   fifo_cnt,
    output logic                     busy
);

    localparam int unsigned TW = $clog2(TMO);
    localparam logic [TW-1:0]   TMO_LAST = TW'(TMO - 1);
    localparam logic [BRKW-1:0] BRK_ONE  = BRKW'(1);

    state_t          state;
    logic            rr;          // 0 = A wins next contention, 1 = B
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic [7:0]      push_data;
    logic [7:0]      head;
    logic [TW-1:0]   tmo_cnt;
    logic [BRKW-1:0] brk_cnt;
    logic [BRKW-1:0] brk_len_q;
    logic            brk_pend;

    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (!full) begin
            if (req_a && (!req_b || !rr))
                gnt_a = 1'b1;
            else if (req_b)
                gnt_b = 1'b1;
        end
    end

    assign push      = gnt_a | gnt_b;
    assign push_data = gnt_a ? data_a : data_b;
    assign pop       = (state == ST_WR);
    assign busy      = (state != ST_IDLE) | (fifo_cnt != '0);

    j_txfifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .sys_clk (sys_clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .wdata   (push_data),
        .rdata   (head),
        .full    (full),
        .empty   (empty),
        .cnt     (fifo_cnt)
    );

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            rr <= 1'b0;
        end else if (gnt_a && req_b) begin
            rr <= 1'b1;
        end else if (gnt_b && req_a) begin
            rr <= 1'b0;
        end
    end

    // Entering BRK consumes the pending request; brk_go while in BRK is dropped.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            brk_pend  <= 1'b0;
            brk_len_q <= '0;
        end else if (state == ST_IDLE && brk_pend) begin
            brk_pend <= 1'b0;
        end else if (brk_go && state != ST_BRK) begin
            brk_pend  <= 1'b1;
            brk_len_q <= brk_len;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            u2dwr   <= 1'b0;
            din     <= '0;
            txbrk   <= 1'b0;
            tmo_cnt <= '0;
            brk_cnt <= '0;
        end else begin
            u2dwr <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (brk_pend) begin
                        state   <= ST_BRK;
                        txbrk   <= 1'b1;
                        brk_cnt <= (brk_len_q == '0) ? BRK_ONE : brk_len_q;
                    end else if (!empty && tbe) begin
                        state <= ST_WR;
                        u2dwr <= 1'b1;
                        din   <= {DIN_PAD, head};
                    end
                end
                ST_WR: begin
                    state   <= ST_WLOW;
                    tmo_cnt <= '0;
                end
                ST_WLOW: begin
                    if (!tbe)
                        state <= ST_WHIGH;
                    else if (tmo_cnt == TMO_LAST)
                        state <= ST_IDLE;
                    else
                        tmo_cnt <= tmo_cnt + TW'(1);
                end
                ST_WHIGH: begin
                    if (tbe)
                        state <= ST_IDLE;
                end
                ST_BRK: begin
                    if (brk_cnt == BRK_ONE) begin
                        state <= ST_IDLE;
                        txbrk <= 1'b0;
                    end else begin
                        brk_cnt <= brk_cnt - BRK_ONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    txbrk <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_j_txsched.sv
// Directed self-checking bench for j_txsched with a simple tbe transmitter model.
module tb_j_txsched;

    logic        sys_clk = 1'b0;
    logic        reset;
    logic        req_a, req_b, gnt_a, gnt_b;
    logic [7:0]  data_a, data_b;
    logic        brk_go;
    logic [15:0] brk_len;
    logic        tbe;
    logic        u2dwr;
    logic [15:0] din;
    logic        txbrk;
    logic [2:0]  fifo_cnt;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic model_on = 1'b0;
    logic tbe_man  = 1'b1;
    logic tbe_mdl  = 1'b1;
    int   mt       = 0;

    logic [7:0] wlog[$];
    int         wcyc[$];
    logic [7:0] gq[$];

    always #5 sys_clk = ~sys_clk;

    assign tbe = model_on ? tbe_mdl : tbe_man;

    j_txsched #(
        .DEPTH (4),
        .TMO   (64),
        .BRKW  (16)
    ) dut (
        .sys_clk  (sys_clk),
        .reset    (reset),
        .req_a    (req_a),
        .data_a   (data_a),
        .gnt_a    (gnt_a),
        .req_b    (req_b),
        .data_b   (data_b),
        .gnt_b    (gnt_b),
        .brk_go   (brk_go),
        .brk_len  (brk_len),
        .tbe      (tbe),
        .u2dwr    (u2dwr),
        .din      (din),
        .txbrk    (txbrk),
        .fifo_cnt (fifo_cnt),
        .busy     (busy)
    );

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Write log and transmitter model: tbe low for 4 cycles starting ~3 cycles after a write.
    always @(negedge sys_clk) begin
        if (u2dwr === 1'b1) begin
            wlog.push_back(din[7:0]);
            wcyc.push_back(cyc);
            mt = 1;
        end else if (mt != 0) begin
            mt = (mt == 7) ? 0 : mt + 1;
        end
        tbe_mdl = !(mt >= 3 && mt < 7);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic wait_idle(input string tag, input int lim);
        for (int i = 0; i < lim; i++) begin
            if (busy === 1'b0) break;
            step();
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic wait_writes(input string tag, input int n, input int lim);
        for (int i = 0; i < lim; i++) begin
            if (wlog.size() >= n) break;
            step();
        end
        check(tag, 32'(wlog.size()), 32'(n));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int na, nb, n0, hi;
        logic saw_full, seen;
        logic [7:0] e;

        reset = 1'b1; req_a = 1'b0; req_b = 1'b0; data_a = '0; data_b = '0;
        brk_go = 1'b0; brk_len = '0;
        step(); step();
        check("rst_u2dwr", 32'(u2dwr), 0);
        check("rst_din", 32'(din), 0);
        check("rst_txbrk", 32'(txbrk), 0);
        check("rst_cnt", 32'(fifo_cnt), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_gnt", {30'd0, gnt_a, gnt_b}, 0);
        reset = 1'b0;
        step();

        // Single byte through the live tbe model
        model_on = 1'b1;
        req_a = 1'b1; data_a = 8'h55; #1;
        check("t1_gnt_a", 32'(gnt_a), 1);
        check("t1_gnt_b", 32'(gnt_b), 0);
        step(); req_a = 1'b0;
        check("t1_cnt1", 32'(fifo_cnt), 1);
        check("t1_nowr", 32'(u2dwr), 0);
        step();
        check("t1_u2dwr", 32'(u2dwr), 1);
        check("t1_din", 32'(din), 32'h0055);
        step();
        check("t1_u2dwr_off", 32'(u2dwr), 0);
        check("t1_cnt0", 32'(fifo_cnt), 0);
        check("t1_busy", 32'(busy), 1);
        wait_idle("t1_idle", 40);
        check("t1_nwr", 32'(wlog.size()), 1);

        // Contention: alternating grants, stall while full
        na = 0; nb = 0; saw_full = 1'b0;
        for (int i = 0; i < 300 && (na + nb) < 6; i++) begin
            req_a = 1'b1; req_b = 1'b1;
            data_a = 8'(8'hA0 + na); data_b = 8'(8'hB0 + nb);
            #1;
            if (fifo_cnt == 3'd4) begin
                saw_full = 1'b1;
                check("t2_full_nogrant", {30'd0, gnt_a, gnt_b}, 0);
            end
            if (gnt_a) begin gq.push_back(data_a); na++; end
            if (gnt_b) begin gq.push_back(data_b); nb++; end
            step();
        end
        req_a = 1'b0; req_b = 1'b0;
        check("t2_saw_full", 32'(saw_full), 1);
        check("t2_ngrants", 32'(gq.size()), 6);
        wait_idle("t2_idle", 200);
        check("t2_nwr", 32'(wlog.size()), 7);
        for (int i = 0; i < 6; i++) begin
            e = (i % 2 == 0) ? 8'(8'hA0 + i / 2) : 8'(8'hB0 + i / 2);
            if (i < gq.size()) check("t2_grant_order", 32'(gq[i]), 32'(e));
            if (i + 1 < wlog.size()) check("t2_write_order", 32'(wlog[i + 1]), 32'(e));
        end

        // Timeout: tbe stuck high
        model_on = 1'b0; tbe_man = 1'b1;
        n0 = wlog.size();
        req_a = 1'b1; data_a = 8'h11; step();
        data_a = 8'h22; step();
        req_a = 1'b0;
        wait_writes("t3_nwr", n0 + 2, 200);
        if (wlog.size() >= n0 + 2) begin
            check("t3_first", 32'(wlog[n0]), 32'h11);
            check("t3_second", 32'(wlog[n0 + 1]), 32'h22);
            check("t3_gap", 32'(wcyc[n0 + 1] - wcyc[n0]), 66);
        end
        wait_idle("t3_idle", 200);

        // Break requested while a byte is in flight
        n0 = wlog.size();
        req_a = 1'b1; data_a = 8'h33; step();
        data_a = 8'h44; step();
        req_a = 1'b0;
        check("t4_wr33", 32'(u2dwr), 1);
        check("t4_din33", 32'(din), 32'h0033);
        step();
        tbe_man = 1'b0; brk_go = 1'b1; brk_len = 16'd10;
        step();
        brk_go = 1'b0;
        check("t4_nobrk_whigh0", 32'(txbrk), 0);
        step();
        check("t4_nobrk_whigh1", 32'(txbrk), 0);
        tbe_man = 1'b1;
        step();
        check("t4_nobrk_idle", 32'(txbrk), 0);
        check("t4_nowr_idle", 32'(u2dwr), 0);
        step();
        check("t4_brk_on", 32'(txbrk), 1);
        hi = 1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (txbrk !== 1'b1) break;
            hi++;
        end
        check("t4_brk_len10", 32'(hi), 10);
        check("t4_nwr_during_brk", 32'(wlog.size()), 32'(n0 + 1));
        wait_writes("t4_nwr44", n0 + 2, 20);
        if (wlog.size() >= n0 + 2) check("t4_din44", 32'(wlog[n0 + 1]), 32'h44);
        wait_idle("t4_idle", 200);
        brk_go = 1'b1; brk_len = 16'd0; step();
        brk_go = 1'b0; step();
        check("t4_brk0_on", 32'(txbrk), 1);
        step();
        check("t4_brk0_off", 32'(txbrk), 0);
        wait_idle("t4_idle2", 10);

        // Simultaneous push and pop
        tbe_man = 1'b0;
        n0 = wlog.size();
        req_a = 1'b1; data_a = 8'h61; step();
        data_a = 8'h62; step();
        req_a = 1'b0;
        check("t5_cnt2", 32'(fifo_cnt), 2);
        tbe_man = 1'b1;
        step();
        check("t5_wr61", 32'(u2dwr), 1);
        check("t5_din61", 32'(din), 32'h0061);
        req_b = 1'b1; data_b = 8'h63; #1;
        check("t5_gnt_b", 32'(gnt_b), 1);
        step();
        req_b = 1'b0;
        check("t5_cnt_hold", 32'(fifo_cnt), 2);
        wait_writes("t5_nwr", n0 + 3, 300);
        if (wlog.size() >= n0 + 3) begin
            check("t5_ord1", 32'(wlog[n0 + 1]), 32'h62);
            check("t5_ord2", 32'(wlog[n0 + 2]), 32'h63);
        end
        wait_idle("t5_idle", 200);

        // Reset in WHIGH with queued bytes and a pending break
        tbe_man = 1'b0;
        req_a = 1'b1;
        data_a = 8'h71; step();
        data_a = 8'h72; step();
        data_a = 8'h73; step();
        data_a = 8'h74; step();
        req_a = 1'b0;
        check("t6_cnt4", 32'(fifo_cnt), 4);
        tbe_man = 1'b1; step();
        step();
        tbe_man = 1'b0; brk_go = 1'b1; brk_len = 16'd5; step();
        brk_go = 1'b0;
        check("t6_cnt3", 32'(fifo_cnt), 3);
        check("t6_busy", 32'(busy), 1);
        reset = 1'b1; step();
        check("t6_cnt0", 32'(fifo_cnt), 0);
        check("t6_txbrk", 32'(txbrk), 0);
        check("t6_u2dwr", 32'(u2dwr), 0);
        check("t6_idle", 32'(busy), 0);
        reset = 1'b0; tbe_man = 1'b1;
        n0 = wlog.size(); seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (txbrk === 1'b1 || u2dwr === 1'b1) seen = 1'b1;
        end
        check("t6_quiet", 32'(seen), 0);
        check("t6_nwr", 32'(wlog.size()), 32'(n0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/j_txsched.md
Name: j_txsched

Overview:
- Transmit scheduler for the UART transmit datapath. Two byte requesters (CPU register path A, DSP path B) share one transmitter through a round-robin arbiter and a small shared FIFO.
- A sequencer drains the FIFO into the transmitter's holding register: it drives u2dwr/din and paces on the transmitter's tbe (transmit buffer empty) flag.
- It also times break generation (txbrk) so a break never corrupts a byte in flight.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- TMO, 64, cycles to wait for tbe to fall after a write before proceeding anyway.
- BRKW, 16, width of the break-length counter.

Ports:
- sys_clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high.
- req_a  in  1  requester A has a byte.
- data_a  in  8  requester A byte.
- gnt_a  out  1  byte A captured this cycle.
- req_b  in  1  requester B has a byte.
- data_b  in  8  requester B byte.
- gnt_b  out  1  byte B captured this cycle.
- brk_go  in  1  pulse: start a break.
- brk_len  in  BRKW  break length in sys_clk cycles; 0 is treated as 1.
- tbe  in  1  transmitter buffer empty (1 = may write).
- u2dwr  out  1  holding-register write strobe, one cycle.
- din  out  16  write data; {8'h00, byte}.
- txbrk  out  1  break force to transmitter.
- fifo_cnt  out  log2(DEPTH)+1  FIFO occupancy.
- busy  out  1  high when the FSM is not IDLE or the FIFO is non-empty.

Behaviour:
- Reset (sync, active-high): FIFO empty, fifo_cnt=0, rr pointer = A, FSM=IDLE, u2dwr=0, din=0, txbrk=0, gnt_a=gnt_b=0, brk_pend=0. Reset mid-byte discards FIFO contents and any pending break.
- Arbiter (combinational grant, registered capture):
  - gnt_x = req_x & ~full & (arbiter picks x).
  - One request alone wins.
  - Both requesting: winner is rr; rr then toggles to the loser. rr changes only on a double-request grant.
  - The granted byte is written to the FIFO on the same sys_clk edge.
- Simultaneous push and pop:
  - Allowed when not empty; count is unchanged.
  - When full, no grant is issued, even if a pop occurs that cycle. Grant is never speculative.
- FIFO: read pointer and write pointer wrap modulo DEPTH; full = (cnt==DEPTH).
- FSM states:
  - IDLE:
    - If brk_pend, go to BRK.
    - Else if FIFO non-empty and tbe=1, go to WR.
    - Break has priority over data.
  - WR:
    - u2dwr=1 for exactly this cycle; din = {8'h00, fifo head}.
    - FIFO pops this cycle.
    - Next state is WLOW; timeout counter is cleared.
  - WLOW:
    - Waits for tbe=0, which confirms the transmitter took the byte; then go to WHIGH.
    - If the counter reaches TMO-1 with tbe still 1, go to IDLE. Recovers from a missed acknowledge.
  - WHIGH: waits for tbe=1, then go to IDLE.
  - BRK:
    - On entry, load counter = max(brk_len,1); txbrk=1 while in BRK.
    - Decrement each cycle; at 1, go to IDLE with txbrk=0 on the next cycle.
    - brk_pend clears on entry to BRK.
- Break request:
  - brk_go sets brk_pend; brk_len is sampled into brk_len_q at that time.
  - brk_go while already in BRK reloads neither the counter nor brk_pend. It is ignored.
  - A break requested during WR/WLOW/WHIGH waits until IDLE, so the in-flight byte completes first.
- Latency:
  - Empty FIFO and tbe=1: push at edge n gives u2dwr high in cycle n+2 (IDLE→WR).
  - Back-to-back writes are separated by at least the transmitter's tbe fall/rise time.
- u2dwr is a registered output and is never high for 2 consecutive cycles.
- busy = (state!=IDLE) | (cnt!=0).

Decomposition:
- Shared package j_txsched_pkg: FSM state encoding (IDLE, WR, WLOW, WHIGH, BRK as a 3-bit enum) and constant DIN_PAD=8'h00.
- One sub-module is natural: j_txfifo, a parameterised DEPTH×8 synchronous FIFO with push, pop, full, empty and cnt.
- The arbiter and FSM stay in the top level.

Test Plan:
- Single byte: req_a with data_a=8'h55 for 1 cycle, tbe=1 → gnt_a same cycle; u2dwr 2 cycles later with din=16'h0055. Model tbe low 3 cycles later, then high → FSM returns to IDLE and busy falls.
- Contention: req_a and req_b held, data A=8'hA0+k, B=8'hB0+k, tbe model live → writes alternate A0,B0,A1,B1…; a full FIFO (cnt=4) produces no grants until a pop.
- Timeout: tbe stuck at 1, push 8'h11 and 8'h22 → u2dwr for 11, then TMO=64 cycles in WLOW, then u2dwr for 22.
- Break during byte: push 8'h33, pulse brk_go with brk_len=10 during WLOW → txbrk rises only after WHIGH completes and is high exactly 10 cycles. A queued 8'h44 is written after the break. brk_len=0 gives 1 cycle.
- Simultaneous push/pop: FIFO at cnt=2, a push in the WR cycle → cnt stays 2 and order is preserved.
- Reset mid-operation: reset asserted in WHIGH with cnt=3 and brk_pend=1 → next cycle: IDLE, cnt=0, txbrk=0, u2dwr=0, no further writes.
